mmio_io_regs: RTL and testbench

Memory-mapped I/O responder between the CPU data port and the VGA/button hardware. Decodes CPU stores and loads aimed at the sprite-coordinate addresses and the button-status address. Holds CPU-written coordinates in shadow registers and commits them to the VGA-facing active registers only at frame boundaries, so sprites never tear. Also synchronizes, debounces and edge-latches the start/left/right buttons for the CPU to poll.

---
 rtl/mmio_io_regs.sv | 137 +++++++++++++
 tb/tb_mmio_io_regs.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_regs.sv
// rtl/mmio_io_regs.sv - CPU-facing sprite coordinate and button status registers
// Shadow coordinates commit to the VGA side on frame_tick; buttons are synced, debounced, edge-latched.
module mmio_io_regs #(
  parameter int WIDTH           = 16,
  parameter int MX              = 6000,
  parameter int MY              = 6004,
  parameter int P1X             = 6008,
  parameter int P1Y             = 6012,
  parameter int P2X             = 6016,
  parameter int P2Y             = 6020,
  parameter int BTN             = 6024,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_BITS         = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mem_address,
  input  logic [WIDTH-1:0] data_to_mem_store,
  input  logic             write_to_memory,
  input  logic             reading_for_load,
  input  logic             frame_tick,
  input  logic             start,
  input  logic             left,
  input  logic             right,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             hit,
  output logic [WIDTH-1:0] mx,
  output logic [WIDTH-1:0] my,
  output logic [WIDTH-1:0] p1x,
  output logic [WIDTH-1:0] p1y,
  output logic [WIDTH-1:0] p2x,
  output logic [WIDTH-1:0] p2y
);

  localparam logic [WIDTH-1:0]   A_MX    = WIDTH'(MX);
  localparam logic [WIDTH-1:0]   A_MY    = WIDTH'(MY);
  localparam logic [WIDTH-1:0]   A_P1X   = WIDTH'(P1X);
  localparam logic [WIDTH-1:0]   A_P1Y   = WIDTH'(P1Y);
  localparam logic [WIDTH-1:0]   A_P2X   = WIDTH'(P2X);
  localparam logic [WIDTH-1:0]   A_P2Y   = WIDTH'(P2Y);
  localparam logic [WIDTH-1:0]   A_BTN   = WIDTH'(BTN);
  localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DEBOUNCE_CYCLES - 1);

  logic [5:0][WIDTH-1:0]   shadow;
  logic [5:0][WIDTH-1:0]   active;
  logic [2:0]              sel_idx;
  logic                    coord_hit;
  logic                    btn_hit;
  logic                    do_load;
  logic [2:0]              btn_raw;
  logic [2:0]              sync1;
  logic [2:0]              sync2;
  logic [2:0]              db;
  logic [2:0]              sticky;
  logic [2:0]              clr;
  logic [2:0][DB_BITS-1:0] cnt;
  logic [WIDTH-1:0]        btn_word;

  always_comb begin
    coord_hit = 1'b1;
    sel_idx   = 3'd0;
    case (mem_address)
      A_MX:    sel_idx = 3'd0;
      A_MY:    sel_idx = 3'd1;
      A_P1X:   sel_idx = 3'd2;
      A_P1Y:   sel_idx = 3'd3;
      A_P2X:   sel_idx = 3'd4;
      A_P2Y:   sel_idx = 3'd5;
      default: coord_hit = 1'b0;
    endcase
  end

  assign btn_hit  = (mem_address == A_BTN);
  assign hit      = coord_hit | btn_hit;
  // A store in the same cycle as a load suppresses the response entirely.
  assign do_load  = reading_for_load & hit & ~write_to_memory;
  assign btn_raw  = {start, left, right};
  assign clr      = (write_to_memory & btn_hit) ? data_to_mem_store[5:3] : 3'b000;
  assign btn_word = {{(WIDTH-6){1'b0}}, sticky, db};

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow   <= '0;
      active   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      // Non-blocking read of shadow means a coincident store commits one frame later.
      if (frame_tick) begin
        active <= shadow;
      end
      if (write_to_memory && coord_hit) begin
        shadow[sel_idx] <= data_to_mem_store;
      end
      rd_valid <= do_load;
      if (do_load) begin
        rd_data <= coord_hit ? shadow[sel_idx] : btn_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      sticky <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i]    <= '0;
          sticky[i] <= sticky[i] & ~clr[i];
        end else if (cnt[i] == DB_LAST) begin
          cnt[i]    <= '0;
          db[i]     <= ~db[i];
          // A rising debounced edge outranks a simultaneous clear.
          sticky[i] <= ~db[i] | (sticky[i] & ~clr[i]);
        end else begin
          cnt[i]    <= cnt[i] + DB_BITS'(1);
          sticky[i] <= sticky[i] & ~clr[i];
        end
      end
    end
  end

  assign mx  = active[0];
  assign my  = active[1];
  assign p1x = active[2];
  assign p1y = active[3];
  assign p2x = active[4];
  assign p2y = active[5];

endmodule

// File: tb/tb_mmio_io_regs.sv
// tb/tb_mmio_io_regs.sv - directed self-checking bench for mmio_io_regs
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_mmio_io_regs;

  localparam int W      = 16;
  localparam int A_MX   = 6000;
  localparam int A_MY   = 6004;
  localparam int A_P1X  = 6008;
  localparam int A_P1Y  = 6012;
  localparam int A_P2X  = 6016;
  localparam int A_P2Y  = 6020;
  localparam int A_BTN  = 6024;

  logic         clk;
  logic         reset;
  logic [W-1:0] mem_address;
  logic [W-1:0] data_to_mem_store;
  logic         write_to_memory;
  logic         reading_for_load;
  logic         frame_tick;
  logic         start;
  logic         left;
  logic         right;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         hit;
  logic [W-1:0] mx;
  logic [W-1:0] my;
  logic [W-1:0] p1x;
  logic [W-1:0] p1y;
  logic [W-1:0] p2x;
  logic [W-1:0] p2y;

  int checks;
  int errors;

  mmio_io_regs #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(4),
    .DB_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_address(mem_address),
    .data_to_mem_store(data_to_mem_store),
    .write_to_memory(write_to_memory),
    .reading_for_load(reading_for_load),
    .frame_tick(frame_tick),
    .start(start),
    .left(left),
    .right(right),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .hit(hit),
    .mx(mx),
    .my(my),
    .p1x(p1x),
    .p1y(p1y),
    .p2x(p2x),
    .p2y(p2y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input int addr, input int data);
    mem_address       = W'(addr);
    data_to_mem_store = W'(data);
    write_to_memory   = 1'b1;
    tick();
    write_to_memory   = 1'b0;
  endtask

  task automatic do_load(input int addr);
    mem_address      = W'(addr);
    reading_for_load = 1'b1;
    tick();
    reading_for_load = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mem_address = '0;
    #1;
    checks++;
    if ({mx, my, p1x, p1y, p2x, p2y} !== '0) begin
      errors++;
      $display("FAIL reset_coords got %h want 0", {mx, my, p1x, p1y, p2x, p2y});
    end
    checks++;
    if ({rd_valid, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_rd got valid=%b data=%h want 0/0", rd_valid, rd_data);
    end
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_hit_addr0 got %b want 0", hit);
    end
  endtask

  task automatic test_decode();
    int addrs[9] = '{A_MX, A_MY, A_P1X, A_P1Y, A_P2X, A_P2Y, A_BTN, 6028, 6002};
    logic exp_hit[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      mem_address = W'(addrs[i]);
      #1;
      checks++;
      if (hit !== exp_hit[i]) begin
        errors++;
        $display("FAIL decode_hit addr=%0d got %b want %b", addrs[i], hit, exp_hit[i]);
      end
    end
  endtask

  task automatic test_coord_commit();
    do_store(A_P1X, 123);
    do_load(A_P1X);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd123) begin
      errors++;
      $display("FAIL load_p1x got valid=%b data=%0d want 1/123", rd_valid, rd_data);
    end
    checks++;
    if (p1x !== 16'd0) begin
      errors++;
      $display("FAIL p1x_before_frame got %0d want 0", p1x);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'd123) begin
      errors++;
      $display("FAIL rd_valid_drop got valid=%b data=%0d want 0/123", rd_valid, rd_data);
    end
    pulse_frame();
    checks++;
    if (p1x !== 16'd123) begin
      errors++;
      $display("FAIL p1x_after_frame got %0d want 123", p1x);
    end
  endtask

  task automatic test_frame_coincide();
    frame_tick = 1'b1;
    do_store(A_MY, 77);
    frame_tick = 1'b0;
    checks++;
    if (my !== 16'd0 || p1x !== 16'd123) begin
      errors++;
      $display("FAIL coincide_commit got my=%0d p1x=%0d want 0/123", my, p1x);
    end
    tick();
    checks++;
    if (my !== 16'd0) begin
      errors++;
      $display("FAIL my_holds_between_frames got %0d want 0", my);
    end
    pulse_frame();
    checks++;
    if (my !== 16'd77) begin
      errors++;
      $display("FAIL my_next_frame got %0d want 77", my);
    end
  endtask

  task automatic test_debounce_left();
    // Edge k (k=1 first sampling left=1) loads db as it stood after edge k-1.
    left             = 1'b1;
    mem_address      = W'(A_BTN);
    reading_for_load = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h000) begin
          errors++;
          $display("FAIL db_left_edge5 got valid=%b data=%h want 1/000", rd_valid, rd_data);
        end
      end
      if (k == 7) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h012) begin
          errors++;
          $display("FAIL db_left_edge6 got valid=%b data=%h want 1/012", rd_valid, rd_data);
        end
      end
    end
    reading_for_load = 1'b0;
    do_load(A_BTN);
    checks++;
    if (rd_data !== 16'h012) begin
      errors++;
      $display("FAIL load_not_clearing got %h want 012", rd_data);
    end
    do_store(A_BTN, 16'h010);
    do_load(A_BTN);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h002) begin
      errors++;
      $display("FAIL w1c_sticky_left got valid=%b data=%h want 1/002", rd_valid, rd_data);
    end
  endtask

  task automatic test_glitch_right();
    right = 1'b1;
    tick();
    tick();
    tick();
    right = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    do_load(A_BTN);
    checks++;
    if (rd_data !== 16'h002) begin
      errors++;
      $display("FAIL glitch_right got %h want 002", rd_data);
    end
  endtask

  task automatic test_unmapped_and_collide();
    mem_address      = W'(6028);
    reading_for_load = 1'b1;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL unmapped_hit got %b want 0", hit);
    end
    tick();
    reading_for_load = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h002) begin
      errors++;
      $display("FAIL unmapped_load got valid=%b data=%h want 0/002", rd_valid, rd_data);
    end
    reading_for_load = 1'b1;
    do_store(A_MX, 55);
    reading_for_load = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_no_valid got %b want 0", rd_valid);
    end
    do_load(A_MX);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd55) begin
      errors++;
      $display("FAIL collide_store_done got valid=%b data=%0d want 1/55", rd_valid, rd_data);
    end
  endtask

  task automatic test_back_to_back();
    reading_for_load = 1'b1;
    mem_address      = W'(A_P1X);
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd123) begin
      errors++;
      $display("FAIL b2b_first got valid=%b data=%0d want 1/123", rd_valid, rd_data);
    end
    mem_address = W'(A_MY);
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd77) begin
      errors++;
      $display("FAIL b2b_second got valid=%b data=%0d want 1/77", rd_valid, rd_data);
    end
    reading_for_load = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'd77) begin
      errors++;
      $display("FAIL b2b_hold got valid=%b data=%0d want 0/77", rd_valid, rd_data);
    end
  endtask

  task automatic test_reset_mid();
    int addrs[6] = '{A_MX, A_MY, A_P1X, A_P1Y, A_P2X, A_P2Y};
    left = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    for (int i = 0; i < 6; i++) do_store(addrs[i], i + 1);
    pulse_frame();
    checks++;
    if ({mx, my, p1x, p1y, p2x, p2y} !== {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6}) begin
      errors++;
      $display("FAIL commit_all got %h want 1..6", {mx, my, p1x, p1y, p2x, p2y});
    end
    for (int i = 0; i < 6; i++) do_store(addrs[i], 100 + i);
    left = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({mx, my, p1x, p1y, p2x, p2y} !== '0 || rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got coords=%h valid=%b data=%h want 0", {mx, my, p1x, p1y, p2x, p2y}, rd_valid, rd_data);
    end
    do_load(A_BTN);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h000) begin
      errors++;
      $display("FAIL reset_mid_btn got valid=%b data=%h want 1/000", rd_valid, rd_data);
    end
    for (int i = 0; i < 6; i++) begin
      do_load(addrs[i]);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'd0) begin
        errors++;
        $display("FAIL reset_mid_shadow addr=%0d got valid=%b data=%0d want 1/0", addrs[i], rd_valid, rd_data);
      end
    end
    pulse_frame();
    checks++;
    if ({mx, my, p1x, p1y, p2x, p2y} !== '0) begin
      errors++;
      $display("FAIL post_reset_frame got %h want 0", {mx, my, p1x, p1y, p2x, p2y});
    end
    left = 1'b0;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    reset             = 1'b1;
    mem_address       = '0;
    data_to_mem_store = '0;
    write_to_memory   = 1'b0;
    reading_for_load  = 1'b0;
    frame_tick        = 1'b0;
    start             = 1'b0;
    left              = 1'b0;
    right             = 1'b0;
    test_reset();
    test_decode();
    test_coord_commit();
    test_frame_coincide();
    test_debounce_left();
    test_glitch_right();
    test_unmapped_and_collide();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
